// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: controller state type and the latch-control patterns driven by each pipeline decision
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, MEMWAIT, HALTED} pipe_state_t;
  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
    logic f_ifid;
    logic f_idex;
    logic f_exmem;
  } ctl_t;
  localparam ctl_t CTL_OFF    = 8'b0000_0000;
  localparam ctl_t CTL_GO     = 8'b1111_1000;
  localparam ctl_t CTL_HALT   = 8'b0000_1001;
  localparam ctl_t CTL_BRANCH = 8'b1111_1110;
  localparam ctl_t CTL_STALL  = 8'b0011_1010;
  localparam ctl_t CTL_JUMP   = 8'b1111_1100;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard observation inputs and latch enable/flush outputs of the pipeline controller
interface pipe_ctrl_if #(parameter int REGBITS = 5, parameter int CNTW = 32);
  logic ihit, dhit;
  logic [REGBITS-1:0] id_rs, id_rt;
  logic id_use_rs, id_use_rt, id_jump;
  logic ex_regwrite, ex_dren, ex_branch_taken;
  logic [REGBITS-1:0] ex_wsel;
  logic mem_regwrite, mem_dren, mem_dwen, mem_halt;
  logic [REGBITS-1:0] mem_wsel;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, halted;
  logic [CNTW-1:0] stall_cycles;
  modport master (
    output ihit, dhit, id_rs, id_rt, id_use_rs, id_use_rt, id_jump,
           ex_regwrite, ex_dren, ex_branch_taken, ex_wsel,
           mem_regwrite, mem_dren, mem_dwen, mem_halt, mem_wsel,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, stall_cycles
  );
  modport slave (
    input  ihit, dhit, id_rs, id_rt, id_use_rs, id_use_rt, id_jump,
           ex_regwrite, ex_dren, ex_branch_taken, ex_wsel,
           mem_regwrite, mem_dren, mem_dwen, mem_halt, mem_wsel,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: RAW stall comparator; PIPE_CTRL_FORWARDING_EN reduces it to the EX load-use case
module hazard_detect #(parameter int REGBITS = 5) (
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic               ex_regwrite,
  input  logic               ex_dren,
  input  logic [REGBITS-1:0] ex_wsel,
  input  logic               mem_regwrite,
  input  logic [REGBITS-1:0] mem_wsel,
  output logic               raw_stall
);
`ifdef PIPE_CTRL_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic ex_hit, mem_hit;
  // $0 is hardwired, so a producer targeting it never creates a dependency
  function automatic logic reads(input logic [REGBITS-1:0] w);
    return (w != '0) && ((id_use_rs && id_rs == w) || (id_use_rt && id_rt == w));
  endfunction
  assign ex_hit    = ex_regwrite & reads(ex_wsel);
  assign mem_hit   = mem_regwrite & reads(mem_wsel);
  assign raw_stall = FWD ? (ex_hit & ex_dren) : (ex_hit | mem_hit);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing FSM, latch enable/flush priority mux and stall counter
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REGBITS = 5,
  parameter int CNTW    = 32
) (
  input logic       CLK,
  input logic       nRST,
  pipe_ctrl_if.slave bus
);
  pipe_state_t state_q, state_d;
  logic halted_q;
  logic [CNTW-1:0] stall_q, stall_d;
  logic raw_stall, freeze;
  ctl_t run_ctl, ctl;
  hazard_detect #(.REGBITS(REGBITS)) u_hd (
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_use_rs   (bus.id_use_rs),
    .id_use_rt   (bus.id_use_rt),
    .ex_regwrite (bus.ex_regwrite),
    .ex_dren     (bus.ex_dren),
    .ex_wsel     (bus.ex_wsel),
    .mem_regwrite(bus.mem_regwrite),
    .mem_wsel    (bus.mem_wsel),
    .raw_stall   (raw_stall)
  );
  assign freeze = (bus.mem_dren | bus.mem_dwen) & ~bus.dhit;
  // every non-freeze pattern keeps memwb_en high, which also retires the access finishing in MEMWAIT
  always_comb run_ctl = bus.mem_halt        ? CTL_HALT
                      : bus.ex_branch_taken ? CTL_BRANCH
                      : raw_stall           ? CTL_STALL
                      : bus.id_jump         ? CTL_JUMP
                      : !bus.ihit           ? CTL_STALL
                      : CTL_GO;
  always_comb begin
    state_d = state_q;
    ctl     = CTL_OFF;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN: begin
        ctl     = freeze ? CTL_OFF : run_ctl;
        state_d = freeze ? MEMWAIT : bus.mem_halt ? HALTED : RUN;
      end
      MEMWAIT: begin
        ctl     = bus.dhit ? run_ctl : CTL_OFF;
        state_d = !bus.dhit ? MEMWAIT : bus.mem_halt ? HALTED : RUN;
      end
      default: state_d = HALTED;
    endcase
  end
  assign stall_d = ((state_q inside {RUN, MEMWAIT}) && !ctl.pc && stall_q != '1) ? stall_q + CNTW'(1) : stall_q;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= state_d == HALTED;
      stall_q  <= stall_d;
    end
  assign bus.pc_en        = ctl.pc;
  assign bus.ifid_en      = ctl.ifid;
  assign bus.idex_en      = ctl.idex;
  assign bus.exmem_en     = ctl.exmem;
  assign bus.memwb_en     = ctl.memwb;
  assign bus.ifid_flush   = ctl.f_ifid;
  assign bus.idex_flush   = ctl.f_idex;
  assign bus.exmem_flush  = ctl.f_exmem;
  assign bus.halted       = halted_q;
  assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a cycle-level behavioural model
module tb_pipe_ctrl;
  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;
  pipe_ctrl_if #(.REGBITS(5), .CNTW(32)) bus();
  pipe_ctrl #(.REGBITS(5), .CNTW(32)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
`ifdef PIPE_CTRL_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  int n_chk  = 0;
  int n_fail = 0;
  bit m_on, m_wait, m_halt;
  longint unsigned m_stalls;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return r != 0 && ((bus.id_use_rs && bus.id_rs == r) || (bus.id_use_rt && bus.id_rt == r));
  endfunction

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, exmem_flush}
  function automatic logic [7:0] model_ctl();
    bit haz;
    haz = FWD ? (bus.ex_dren && bus.ex_regwrite && reads(bus.ex_wsel))
              : (bus.ex_regwrite && reads(bus.ex_wsel)) || (bus.mem_regwrite && reads(bus.mem_wsel));
    if (!m_on || m_halt) return 8'b0;
    if (!bus.dhit && (m_wait || bus.mem_dren || bus.mem_dwen)) return 8'b0;
    if (bus.mem_halt) return 8'b0000_1001;
    if (bus.ex_branch_taken) return 8'b1111_1110;
    if (haz) return 8'b0011_1010;
    if (bus.id_jump) return 8'b1111_1100;
    if (!bus.ihit) return 8'b0011_1010;
    return 8'b1111_1000;
  endfunction

  function automatic logic [7:0] dut_ctl();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
  endfunction

  always @(negedge CLK) begin : cmp
    logic [7:0] e;
    if (!nRST) begin
      m_on = 0; m_wait = 0; m_halt = 0; m_stalls = 0;
      chk("reset_ctl", dut_ctl(), 0);
      chk("reset_halted", bus.halted, 0);
      chk("reset_stalls", bus.stall_cycles, 0);
    end else begin
      e = model_ctl();
      chk("ctl", dut_ctl(), e);
      chk("halted", bus.halted, m_halt);
      chk("stall_cycles", bus.stall_cycles, m_stalls);
      if (m_on && !m_halt && !e[7] && m_stalls != 64'hFFFF_FFFF) m_stalls++;
      if (!m_on) m_on = 1;
      else if (m_halt) m_halt = 1;
      else if (!bus.dhit && (m_wait || bus.mem_dren || bus.mem_dwen)) m_wait = 1;
      else if (bus.mem_halt) begin m_halt = 1; m_wait = 0; end
      else m_wait = 0;
    end
  end

  task automatic idle_in();
    bus.ihit = 1; bus.dhit = 0; bus.id_rs = 0; bus.id_rt = 0;
    bus.id_use_rs = 0; bus.id_use_rt = 0; bus.id_jump = 0;
    bus.ex_regwrite = 0; bus.ex_dren = 0; bus.ex_wsel = 0; bus.ex_branch_taken = 0;
    bus.mem_regwrite = 0; bus.mem_dren = 0; bus.mem_dwen = 0; bus.mem_halt = 0; bus.mem_wsel = 0;
  endtask
  task automatic cyc();  @(posedge CLK); #1; endtask
  task automatic look(); @(negedge CLK); #1; endtask

  initial begin
    idle_in();
    repeat (3) cyc();
    nRST = 1;
    look(); chk("idle_pc_en", bus.pc_en, 0);
    cyc(); look(); chk("run_pc_en", bus.pc_en, 1); chk("run_stalls", bus.stall_cycles, 0);
    cyc();
    bus.ex_regwrite = 1; bus.ex_dren = 1; bus.ex_wsel = 3;
    bus.id_rs = 3; bus.id_use_rs = 1; bus.id_rt = 5; bus.id_use_rt = 1;
    look(); chk("lu_pc_en", bus.pc_en, 0); chk("lu_idex_flush", bus.idex_flush, 1);
    cyc();
    bus.ex_regwrite = 0; bus.ex_dren = 0; bus.ex_wsel = 0;
    bus.mem_regwrite = 1; bus.mem_dren = 1; bus.dhit = 1; bus.mem_wsel = 3;
    look(); chk("lu2_pc_en", bus.pc_en, FWD ? 1 : 0);
    cyc(); idle_in();
    look(); chk("lu_done_pc_en", bus.pc_en, 1); chk("lu_stalls", bus.stall_cycles, FWD ? 1 : 2);
    cyc(); bus.mem_dren = 1; bus.dhit = 0;
    for (int i = 0; i < 3; i++) begin
      look(); chk("mw_enables", dut_ctl() >> 3, 0);
      cyc();
    end
    bus.dhit = 1;
    look(); chk("mw_dhit_memwb", bus.memwb_en, 1); chk("mw_dhit_pc", bus.pc_en, 1);
    cyc(); idle_in();
    look(); chk("mw_run_pc", bus.pc_en, 1); chk("mw_stalls", bus.stall_cycles, (FWD ? 1 : 2) + 3);
    cyc(); bus.ex_branch_taken = 1; bus.ihit = 0;
    look(); chk("br_ifid_flush", bus.ifid_flush, 1); chk("br_idex_flush", bus.idex_flush, 1);
    chk("br_pc_en", bus.pc_en, 1);
    cyc(); idle_in();
    bus.ex_regwrite = 1; bus.ex_dren = 1; bus.ex_wsel = 0; bus.id_rs = 0; bus.id_use_rs = 1;
    look(); chk("wsel0_pc_en", bus.pc_en, 1);
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (!nRST) nRST = 1;
      else if ($urandom_range(99) == 0 || (bus.halted && $urandom_range(9) == 0)) nRST = 0;
      bus.ihit = $urandom_range(9) != 0;
      bus.dhit = $urandom_range(1) != 0;
      bus.id_rs = 5'($urandom_range(3)); bus.id_rt = 5'($urandom_range(3));
      bus.id_use_rs = $urandom_range(1) != 0; bus.id_use_rt = $urandom_range(1) != 0;
      bus.id_jump = $urandom_range(9) == 0;
      bus.ex_regwrite = $urandom_range(1) != 0; bus.ex_dren = $urandom_range(3) == 0;
      bus.ex_wsel = 5'($urandom_range(3)); bus.ex_branch_taken = $urandom_range(9) == 0;
      bus.mem_regwrite = $urandom_range(1) != 0; bus.mem_dren = $urandom_range(6) == 0;
      bus.mem_dwen = $urandom_range(9) == 0; bus.mem_halt = $urandom_range(99) == 0;
      bus.mem_wsel = 5'($urandom_range(3));
    end
    cyc(); idle_in(); nRST = 0;
    cyc(); nRST = 1;
    cyc(); bus.mem_halt = 1;
    look(); chk("halt_memwb", bus.memwb_en, 1); chk("halt_exmem_flush", bus.exmem_flush, 1);
    chk("halt_pc_en", bus.pc_en, 0);
    cyc(); idle_in();
    for (int i = 0; i < 12; i++) begin
      look(); chk("halted_flag", bus.halted, 1); chk("halted_ctl", dut_ctl(), 0);
      cyc();
    end
    #2 nRST = 0;
    #1 chk("async_reset_halted", bus.halted, 0);
    cyc(); nRST = 1;
    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
